mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single memory port between the instruction fetch unit and the load/store unit: one outstanding transaction at a time, with a response timeout. It arbitrates pending requests, forwards grants and responses to the winning requester, and drives the fetch stall that feeds the fetch unit's `i_stall`. It sits between the core and the memory interconnect (boot ROM / RAM decoder).

## Interface
- `TIMEOUT_CYCLES`, 16: busy cycles without `i_mem_rvalid` before an error response is generated; must be ≥2.
- `XLEN` is taken from `cotm32_pkg`; it is not a parameter.
- `i_clk`  in  1  core clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_if_req`  in  1  fetch request; held high until `o_if_rvalid`.
- `i_if_addr`  in  XLEN  fetch address; stable while `i_if_req` is high.
- `o_if_gnt`  out  1  fetch accepted by memory this cycle.
- `o_if_rvalid`  out  1  fetch response valid.
- `o_if_rdata`  out  XLEN  fetched word.
- `o_if_err`  out  1  fetch bus error or timeout; qualified by `o_if_rvalid`.
- `o_if_stall`  out  1  hold the PC: `i_if_req & ~o_if_rvalid`.
- `i_ls_req`  in  1  data request; held high until `o_ls_rvalid`.
- `i_ls_we`  in  1  data write enable.
- `i_ls_be`  in  4  data byte enables.
- `i_ls_addr`  in  XLEN  data address.
- `i_ls_wdata`  in  XLEN  data write data.
- `o_ls_gnt`, `o_ls_rvalid`, `o_ls_rdata`[XLEN], `o_ls_err`  out  data-side equivalents of the fetch signals.
- `o_mem_req`  out  1  memory request.
- `o_mem_we`  out  1  memory write enable.
- `o_mem_be`  out  4  memory byte enables.
- `o_mem_addr`  out  XLEN  memory address.
- `o_mem_wdata`  out  XLEN  memory write data.
- `i_mem_gnt`  in  1  memory accepts the request this cycle.
- `i_mem_rvalid`  in  1  memory response valid; arrives at least one cycle after grant.
- `i_mem_rdata`  in  XLEN  memory read data.
- `i_mem_err`  in  1  memory error; qualified by `i_mem_rvalid`.

## Operation
- FSM states: `IDLE`, `BUSY_IF`, `BUSY_LS`. Reset → `IDLE`, timeout counter = 0, `last_ls` = 0.
- `IDLE` arbitration (combinational):
  - Winner is chosen from `i_if_req`/`i_ls_req`.
  - Default priority: LS over IF, because the data access belongs to the older instruction.
  - `o_mem_req = i_if_req | i_ls_req`.
  - `o_mem_addr`/`we`/`be`/`wdata` are muxed from the winner. For a fetch winner: `we`=0, `be`=4'hF, `wdata`=0.
- Grant:
  - When `o_mem_req & i_mem_gnt` in `IDLE`, the winner's `gnt` pulses high for that cycle.
  - FSM → `BUSY_IF`/`BUSY_LS`; counter cleared to 0.
  - Without `i_mem_gnt`, stay in `IDLE` and re-arbitrate next cycle (the winner may change).
- `BUSY_x`:
  - `o_mem_req`=0.
  - New requests are not arbitrated. The requester's held req is the in-flight transaction.
- Response on `i_mem_rvalid` in `BUSY_x`:
  - `o_x_rvalid`=1, `o_x_rdata`=`i_mem_rdata`, `o_x_err`=`i_mem_err`, all combinational pass-through.
  - FSM → `IDLE`.
- Timeout:
  - Counter increments each `BUSY` cycle without `i_mem_rvalid`. Width `$clog2(TIMEOUT_CYCLES)+1`; saturation is unnecessary.
  - In the cycle the counter equals `TIMEOUT_CYCLES-1` with no rvalid: `o_x_rvalid`=1, `o_x_err`=1, `o_x_rdata`=0, FSM → `IDLE`.
  - Rvalid in that same cycle wins: real data, `err` = `i_mem_err`.
- `i_mem_rvalid` in `IDLE` (stray/late response after a timeout or reset) is dropped: no requester rvalid.
- Requester rdata outputs are 0 whenever their rvalid is 0.

## Timing
- All outputs are combinational from the state and inputs; there is no added latency on request, grant or response paths.
- Minimum transaction: 2 cycles (grant cycle + rvalid cycle). Next arbitration is the cycle after rvalid (one `IDLE` cycle).
- Reset values: state `IDLE`, counter 0, `last_ls` 0. With all req inputs low, every output is 0.
- Async reset mid-transaction abandons it. No rvalid is issued to the requester; a later memory rvalid is dropped in `IDLE`.
- Simultaneous requests in `IDLE` with `i_mem_gnt`: exactly one `gnt` asserts, never both.

## Configuration
- `COTM32_MEMARB_RR_EN` defined:
  - Round-robin arbitration. `last_ls` is set to 1 on LS grant and 0 on IF grant.
  - When both request, grant the requester not granted last. Reset `last_ls`=0, so LS wins first.
  - Single requesters are granted regardless.
- `COTM32_MEMARB_RR_EN` undefined: fixed LS-over-IF priority; the `last_ls` register is absent.

## Test plan
- Fetch only:
  - Stimulus: `i_if_req`=1, addr `0x100`; `i_mem_gnt` in cycle 0; rvalid with data `0xDEADBEEF` in cycle 2.
  - Required: `o_if_gnt` in cycle 0; `o_if_stall`=1 in cycles 0–1; `o_if_rvalid`=1, rdata `0xDEADBEEF`, `o_if_stall`=0 in cycle 2.
- Simultaneous IF + LS write:
  - Stimulus: LS addr `0x2000`, be 4'b0011, both requests high, memory grants immediately.
  - Required (fixed priority): `o_mem_we`=1, addr `0x2000` first; the fetch is issued the cycle after `o_ls_rvalid`.
- Round-robin (macro defined), both requesting continuously:
  - Required: grants alternate LS, IF, LS, IF.
- Timeout, `TIMEOUT_CYCLES`=4:
  - Stimulus: grant, then no rvalid.
  - Required: `o_ls_rvalid`=1, `o_ls_err`=1, rdata 0 exactly 4 cycles after grant; a late `i_mem_rvalid` in `IDLE` produces no requester rvalid.
- `i_mem_err` response to a fetch:
  - Required: `o_if_rvalid`=1, `o_if_err`=1.
- Reset mid-operation:
  - Stimulus: assert `i_rst_n`=0 in `BUSY_LS`.
  - Required: state `IDLE` immediately, with no clock edge needed; all outputs 0 with requests low; the next request is arbitrated normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | mem_port_arbiter : shares one memory port between fetch and load/store,    |
// | one transaction in flight, response timeout. Option: COTM32_MEMARB_RR_EN.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package cotm32_pkg;
  parameter int XLEN = 32;
endpackage

module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_if_req,
  input  logic [cotm32_pkg::XLEN-1:0] i_if_addr,
  output logic                       o_if_gnt,
  output logic                       o_if_rvalid,
  output logic [cotm32_pkg::XLEN-1:0] o_if_rdata,
  output logic                       o_if_err,
  output logic                       o_if_stall,
  input  logic                       i_ls_req,
  input  logic                       i_ls_we,
  input  logic [3:0]                 i_ls_be,
  input  logic [cotm32_pkg::XLEN-1:0] i_ls_addr,
  input  logic [cotm32_pkg::XLEN-1:0] i_ls_wdata,
  output logic                       o_ls_gnt,
  output logic                       o_ls_rvalid,
  output logic [cotm32_pkg::XLEN-1:0] o_ls_rdata,
  output logic                       o_ls_err,
  output logic                       o_mem_req,
  output logic                       o_mem_we,
  output logic [3:0]                 o_mem_be,
  output logic [cotm32_pkg::XLEN-1:0] o_mem_addr,
  output logic [cotm32_pkg::XLEN-1:0] o_mem_wdata,
  input  logic                       i_mem_gnt,
  input  logic                       i_mem_rvalid,
  input  logic [cotm32_pkg::XLEN-1:0] i_mem_rdata,
  input  logic                       i_mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_LS = 2'd2
  } state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [CNT_W-1:0]               r_cnt;
  logic [CNT_W-1:0]               w_cnt_nxt;
  logic                           w_pick_ls;
  logic                           w_pick_if;
  logic                           w_grant;
  logic                           w_resp;
  logic                           w_resp_err;
  logic [cotm32_pkg::XLEN-1:0]    w_resp_data;

`ifdef COTM32_MEMARB_RR_EN
  logic r_last_ls;

  // On contention the side not granted last time wins; lone requesters always win.
  assign w_pick_ls = i_ls_req & (~i_if_req | ~r_last_ls);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_ls <= 1'b0;
    end else if (w_grant) begin
      r_last_ls <= w_pick_ls;
    end
  end
`else
  // The data access belongs to the older instruction, so it goes first.
  assign w_pick_ls = i_ls_req;
`endif

  assign w_pick_if = i_if_req & ~w_pick_ls;
  assign w_grant   = (r_state == ST_IDLE) & (i_if_req | i_ls_req) & i_mem_gnt;

  // A real response beats the timeout when both land in the same cycle.
  assign w_resp      = i_mem_rvalid | (r_cnt == C_CNT_LAST);
  assign w_resp_err  = i_mem_rvalid ? i_mem_err : 1'b1;
  assign w_resp_data = i_mem_rvalid ? i_mem_rdata : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_be    = 4'h0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_if_gnt    = 1'b0;
    o_ls_gnt    = 1'b0;
    o_if_rvalid = 1'b0;
    o_if_rdata  = '0;
    o_if_err    = 1'b0;
    o_ls_rvalid = 1'b0;
    o_ls_rdata  = '0;
    o_ls_err    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        o_mem_req = i_if_req | i_ls_req;
        if (w_pick_ls) begin
          o_mem_we    = i_ls_we;
          o_mem_be    = i_ls_be;
          o_mem_addr  = i_ls_addr;
          o_mem_wdata = i_ls_wdata;
        end else if (w_pick_if) begin
          o_mem_be    = 4'hF;
          o_mem_addr  = i_if_addr;
        end
        if (w_grant) begin
          w_cnt_nxt = '0;
          if (w_pick_ls) begin
            o_ls_gnt    = 1'b1;
            w_state_nxt = ST_BUSY_LS;
          end else begin
            o_if_gnt    = 1'b1;
            w_state_nxt = ST_BUSY_IF;
          end
        end
      end

      ST_BUSY_IF, ST_BUSY_LS: begin
        if (w_resp) begin
          w_state_nxt = ST_IDLE;
          if (r_state == ST_BUSY_IF) begin
            o_if_rvalid = 1'b1;
            o_if_rdata  = w_resp_data;
            o_if_err    = w_resp_err;
          end else begin
            o_ls_rvalid = 1'b1;
            o_ls_rdata  = w_resp_data;
            o_ls_err    = w_resp_err;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_if_stall = i_if_req & ~o_if_rvalid;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, all
// outputs compared each cycle against a transaction-level reference model.
`default_nettype none

module tb_mem_port_arbiter;
  localparam int XLEN = cotm32_pkg::XLEN;
  localparam int T    = 4;
`ifdef COTM32_MEMARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk, rst_n;
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_gnt, if_rvalid, if_err, if_stall;
  logic [XLEN-1:0] if_rdata;
  logic            ls_req, ls_we;
  logic [3:0]      ls_be;
  logic [XLEN-1:0] ls_addr, ls_wdata;
  logic            ls_gnt, ls_rvalid, ls_err;
  logic [XLEN-1:0] ls_rdata;
  logic            mem_req, mem_we;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_addr, mem_wdata;
  logic            mem_gnt, mem_rvalid, mem_err;
  logic [XLEN-1:0] mem_rdata;

  mem_port_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .o_if_err(if_err), .o_if_stall(if_stall),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_be(ls_be),
    .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
    .o_ls_gnt(ls_gnt), .o_ls_rvalid(ls_rvalid), .o_ls_rdata(ls_rdata),
    .o_ls_err(ls_err),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_be(mem_be),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid),
    .i_mem_rdata(mem_rdata), .i_mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: owner 0=none 1=fetch 2=data; m_n counts busy cycles since grant (1-based).
  int m_owner  = 0;
  int m_n      = 0;
  bit m_last_ls = 1'b0;
  int e_win;
  bit e_if_rv, e_ls_rv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic sample();
    bit            resp;
    logic [XLEN-1:0] rd;
    logic          er;
    @(negedge clk);
    e_win = 0;
    if (m_owner == 0) begin
      if (ls_req && if_req) e_win = (RR && m_last_ls) ? 1 : 2;
      else if (ls_req)      e_win = 2;
      else if (if_req)      e_win = 1;
    end
    resp    = (m_owner != 0) && (mem_rvalid || m_n == T);
    rd      = mem_rvalid ? mem_rdata : '0;
    er      = mem_rvalid ? mem_err : 1'b1;
    e_if_rv = resp && m_owner == 1;
    e_ls_rv = resp && m_owner == 2;
    chk("mem_req",   mem_req,   (m_owner == 0) && (if_req || ls_req));
    chk("mem_we",    mem_we,    (e_win == 2) ? ls_we : 1'b0);
    chk("mem_be",    mem_be,    (e_win == 2) ? ls_be : (e_win == 1) ? 4'hF : 4'h0);
    chk("mem_addr",  mem_addr,  (e_win == 2) ? ls_addr : (e_win == 1) ? if_addr : '0);
    chk("mem_wdata", mem_wdata, (e_win == 2) ? ls_wdata : '0);
    chk("if_gnt",    if_gnt,    e_win == 1 && mem_gnt);
    chk("ls_gnt",    ls_gnt,    e_win == 2 && mem_gnt);
    chk("if_rvalid", if_rvalid, e_if_rv);
    chk("if_rdata",  if_rdata,  e_if_rv ? rd : '0);
    chk("if_err",    if_err,    e_if_rv ? er : 1'b0);
    chk("ls_rvalid", ls_rvalid, e_ls_rv);
    chk("ls_rdata",  ls_rdata,  e_ls_rv ? rd : '0);
    chk("ls_err",    ls_err,    e_ls_rv ? er : 1'b0);
    chk("if_stall",  if_stall,  if_req && !e_if_rv);
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst_n) begin
      m_owner = 0; m_n = 0; m_last_ls = 1'b0;
    end else if (m_owner == 0) begin
      if (e_win != 0 && mem_gnt) begin
        m_owner = e_win; m_n = 1; m_last_ls = (e_win == 2);
      end
    end else if (e_if_rv || e_ls_rv) begin
      m_owner = 0;
    end else begin
      m_n = m_n + 1;
    end
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  initial begin
    rst_n = 1'b0; if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_be = 0;
    ls_addr = '0; ls_wdata = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; mem_err = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_if_stall", if_stall, 1'b0);
    cyc();
    rst_n = 1'b1;

    // Fetch only
    if_req = 1; if_addr = 32'h100; mem_gnt = 1;
    sample(); chk("f_gnt", if_gnt, 1'b1); chk("f_stall0", if_stall, 1'b1); advance();
    mem_gnt = 0;
    sample(); chk("f_stall1", if_stall, 1'b1); advance();
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    sample(); chk("f_rvalid", if_rvalid, 1'b1); chk("f_rdata", if_rdata, 32'hDEADBEEF);
    chk("f_stall2", if_stall, 1'b0); advance();
    if_req = 0; mem_rvalid = 0;
    cyc();

    // Simultaneous fetch and data write
    if_req = 1; if_addr = 32'h104; ls_req = 1; ls_we = 1; ls_be = 4'b0011;
    ls_addr = 32'h2000; ls_wdata = 32'h55AA_1234; mem_gnt = 1;
    sample();
`ifndef COTM32_MEMARB_RR_EN
    chk("s_we", mem_we, 1'b1); chk("s_addr", mem_addr, 32'h2000); chk("s_only_ls", if_gnt, 1'b0);
`endif
    advance();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0;
    cyc();
    if (e_ls_rv) ls_req = 0;
    if (e_if_rv) if_req = 0;
    mem_rvalid = 0; mem_gnt = 1;
    sample();
`ifndef COTM32_MEMARB_RR_EN
    chk("s_if_next", if_gnt, 1'b1); chk("s_if_addr", mem_addr, 32'h104);
`endif
    advance();
    mem_gnt = 0; mem_rvalid = 1;
    cyc();
    if (e_ls_rv) ls_req = 0;
    if (e_if_rv) if_req = 0;
    mem_rvalid = 0; ls_req = 0; if_req = 0; ls_we = 0;
    cyc();

    // Timeout on a data read, then a stray late response
    ls_req = 1; ls_addr = 32'h40; ls_be = 4'hF; mem_gnt = 1;
    sample(); chk("t_gnt", ls_gnt, 1'b1); advance();
    mem_gnt = 0;
    repeat (T - 1) begin
      sample(); chk("t_wait", ls_rvalid, 1'b0); advance();
    end
    sample(); chk("t_rvalid", ls_rvalid, 1'b1); chk("t_err", ls_err, 1'b1);
    chk("t_rdata", ls_rdata, 32'h0); advance();
    ls_req = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
    sample(); chk("t_stray", ls_rvalid, 1'b0); advance();
    mem_rvalid = 0;

    // Fetch answered with a bus error
    if_req = 1; if_addr = 32'h200; mem_gnt = 1;
    cyc();
    mem_gnt = 0; mem_rvalid = 1; mem_err = 1; mem_rdata = 32'h1111;
    sample(); chk("e_rvalid", if_rvalid, 1'b1); chk("e_err", if_err, 1'b1); advance();
    if_req = 0; mem_rvalid = 0; mem_err = 0;

    // Asynchronous reset while a data access is outstanding
    ls_req = 1; ls_we = 0; ls_addr = 32'h3000; mem_gnt = 1;
    cyc();
    mem_gnt = 0;
    cyc();
    ls_req = 0; rst_n = 1'b0;
    #1;
    chk("r_mem_req", mem_req, 1'b0); chk("r_ls_rvalid", ls_rvalid, 1'b0);
    chk("r_ls_gnt", ls_gnt, 1'b0); chk("r_mem_addr", mem_addr, 32'h0);
    m_owner = 0; m_n = 0; m_last_ls = 1'b0;
    cyc();
    rst_n = 1'b1; mem_rvalid = 1;
    sample(); chk("r_stray", ls_rvalid, 1'b0); advance();
    mem_rvalid = 0; if_req = 1; if_addr = 32'h300; mem_gnt = 1;
    sample(); chk("r_next_gnt", if_gnt, 1'b1); advance();
    mem_gnt = 0; mem_rvalid = 1;
    cyc();
    if_req = 0; mem_rvalid = 0;

`ifdef COTM32_MEMARB_RR_EN
    // Both requesting continuously: grants must alternate
    begin
      bit prev_ls = m_last_ls;
      if_req = 1; ls_req = 1;
      repeat (4) begin
        mem_gnt = 1; mem_rvalid = 0;
        sample(); chk("rr_alt", ls_gnt, !prev_ls); prev_ls = ls_gnt; advance();
        mem_gnt = 0; mem_rvalid = 1;
        cyc();
      end
      if_req = 0; ls_req = 0; mem_rvalid = 0;
    end
`endif

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (!if_req && ($urandom % 3 == 0)) begin
        if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!ls_req && ($urandom % 3 == 0)) begin
        ls_req = 1; ls_we = $urandom; ls_be = $urandom; ls_addr = $urandom; ls_wdata = $urandom;
      end
      mem_gnt    = $urandom % 2;
      mem_rvalid = ($urandom % 4 == 0);
      mem_rdata  = $urandom;
      mem_err    = ($urandom % 5 == 0);
      cyc();
      if (e_if_rv) if_req = 0;
      if (e_ls_rv) ls_req = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
